mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-copy initiator for the 8-bit single-port memory: on a start pulse it copies `len` bytes from `src` to `dst` via the memory's address, write-data, write-enable and combinational read-data port. It computes an 8-bit additive checksum of the bytes moved. It sits beside the CPU core. While `busy` is high, the external port arbiter routes the memory port to this block, so the engine is the only initiator on the port.

## Interface
- `ADDR_WIDTH`, default 8: memory address width; all pointer arithmetic wraps modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 8: memory data width and checksum width.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle request pulse; sampled only in IDLE.
- `src`  input  ADDR_WIDTH  first source address; sampled with `start`.
- `dst`  input  ADDR_WIDTH  first destination address; sampled with `start`.
- `len`  input  ADDR_WIDTH  byte count, 0..255; sampled with `start`.
- `busy`  output  1  high from the cycle after an accepted `start` through the FINISH cycle.
- `done`  output  1  one-cycle pulse in FINISH.
- `checksum`  output  DATA_WIDTH  sum of bytes read in the last operation, mod 2^DATA_WIDTH; holds until the next accepted `start`.
- `mem_address`  output  ADDR_WIDTH  memory address.
- `mem_write_data`  output  DATA_WIDTH  memory write data.
- `mem_write_enable`  output  1  memory write strobe; the memory writes at the rising edge.
- `mem_read_data`  input  DATA_WIDTH  combinational read data for the current `mem_address`.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- In IDLE with `start`=1:
  - latch `src`→src_ptr, `dst`→dst_ptr and `len`→remaining;
  - clear checksum to 0;
  - go to READ if `len`≠0, else go to FINISH.
- In IDLE with `start`=0: stay in IDLE.
- READ:
  - drive `mem_address`=src_ptr and `mem_write_enable`=0;
  - at the clock edge, capture `mem_read_data` into the byte buffer;
  - add the byte to checksum;
  - increment src_ptr;
  - go to WRITE.
- WRITE:
  - drive `mem_address`=dst_ptr, `mem_write_data`=buffer and `mem_write_enable`=1;
  - at the clock edge, increment dst_ptr and decrement remaining;
  - go to READ if the pre-decrement remaining was >1, else go to FINISH.
- FINISH: `done`=1, `busy`=1; go to IDLE.
- Copy order is strictly ascending, one byte at a time, with read before write. With overlapping ranges where dst>src, data smears forward; this is the defined behaviour and is not corrected.
- Pointers wrap modulo 256. Example: src=0xFF, len=2 reads 0xFF then 0x00.
- `start` is ignored while `busy`=1. Parameters latched at start are not affected by later input changes.
- In IDLE and FINISH: `mem_address`=0, `mem_write_data`=0, `mem_write_enable`=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, `busy`=0, `done`=0, `checksum`=0;
  - `mem_address`=0, `mem_write_data`=0, `mem_write_enable`=0;
  - internal pointers, remaining count and buffer cleared.
- Reset mid-copy aborts the copy. Bytes already written stay in memory, and no `done` is produced.
- Cycle 0 is the edge where `start` is sampled. READ occupies cycle 1, WRITE cycle 2, and so on.
- Each byte takes 2 cycles. FINISH is cycle 2·len+1. IDLE is re-entered at cycle 2·len+2, where a new `start` can be accepted.
- For `len`=0: FINISH is cycle 1 with no memory access. Checksum is 0.
- The memory outputs are decoded from registered state and pointers, with no combinational path from `start`. `mem_read_data` is used in the same cycle as `mem_address`.
- `checksum` updates at the end of each READ cycle. Its final value is stable from the FINISH cycle onward.

## Test plan
- **Basic copy.** Memory preloaded mem[200]=0x05, mem[201]=0x0A; start with src=200, dst=50, len=2.
  - mem[50]=0x05 and mem[51]=0x0A;
  - `done` high exactly at cycle 5; `checksum`=0x0F;
  - `mem_write_enable` high only in cycles 2 and 4.
- **Zero length.** len=0 →
  - `done` at cycle 1;
  - `mem_write_enable` never asserted;
  - `checksum`=0x00; memory unchanged.
- **Address wrap.** src=0xFF, dst=0x80, len=3 with mem[0xFF]=0x11, mem[0x00]=0x22, mem[0x01]=0x33 →
  - mem[0x80..0x82]=0x11, 0x22, 0x33;
  - `checksum`=0x66.
- **Overlap with checksum overflow.** All bytes = 0x80, src=10, dst=11, len=4 →
  - mem[11..14]=0x80 (smear);
  - `checksum`=0x00 (mod-256 overflow).
- **Start ignored while busy.** Pulse `start` at cycle 2 of a len=2 copy with different src/dst →
  - the first copy completes unchanged;
  - exactly one `done`; no second operation follows.
- **Reset mid-copy.** Assert `reset` during the WRITE of byte 2 of a len=4 copy →
  - `busy`, `done` and `mem_write_enable` go 0 immediately;
  - only byte 1 is written; `checksum`=0.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-serial block copy over a single-port memory.
// Reads one byte, writes it, repeats; keeps an additive checksum.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // State, pointers, count, byte buffer and checksum registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state and datapath; memory port decoded from registered state only.
  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    rem_d            = rem_q;
    buf_d            = buf_q;
    sum_d            = sum_q;
    busy             = 1'b0;
    done             = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          rem_d   = len;
          sum_d   = '0;
          state_d = (len == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        mem_address = src_q;
        buf_d       = mem_read_data;
        sum_d       = sum_q + mem_read_data;
        src_d       = src_q + ADDR_WIDTH'(1);
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        busy             = 1'b1;
        mem_address      = dst_q;
        mem_write_data   = buf_q;
        mem_write_enable = 1'b1;
        dst_d            = dst_q + ADDR_WIDTH'(1);
        rem_d            = rem_q - ADDR_WIDTH'(1);
        // Compare against the count before this decrement.
        state_d          = (rem_q > ADDR_WIDTH'(1)) ? S_READ : S_FINISH;
      end
      S_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign checksum = sum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed copies against a behavioural memory,
// with a write scoreboard filled from a reference copy model.
module tb_mem_copy_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] src, dst, len;
  logic       busy, done;
  logic [7:0] checksum;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write_enable;
  logic [7:0] mem_read_data;

  mem_copy_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .src             (src),
    .dst             (dst),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .checksum        (checksum),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_read_data   (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  wr_t        exp_q  [$];
  logic [7:0] exp_sum;
  logic       pk_en;
  logic [7:0] pk_a, pk_d;
  int         vecs;
  int         errs;
  int         done_cnt;

  assign mem_read_data = mem[mem_address];

  // Memory: bench preload port, otherwise DUT write port.
  always @(posedge clk) begin
    if (pk_en) mem[pk_a] <= pk_d;
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DUT write must match the next expected write.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_address, mem_write_data}, 32'hx);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write", {mem_address, mem_write_data}, {e.a, e.d});
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    shadow[a] = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Reference copy: ascending, read-before-write, so overlap smears.
  task automatic model(input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input int nw);
    logic [7:0] sp, dp, b;
    sp = s; dp = d; exp_sum = 8'h00;
    for (int i = 0; i < int'(l); i++) begin
      b = shadow[sp];
      exp_sum = exp_sum + b;
      if (i < nw) begin
        shadow[dp] = b;
        exp_q.push_back({dp, b});
      end
      sp = sp + 8'd1;
      dp = dp + 8'd1;
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== shadow[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run_op(input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input int inj);
    int n;
    n = int'(l);
    model(s, d, l, n);
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    for (int c = 1; c <= 2 * n + 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; src = ~s; dst = ~d; len = ~l;
      end
      if (c == inj) begin
        start = 1'b1; src = s + 8'd7; dst = d + 8'd9; len = 8'd3;
      end
      if (c == inj + 1) start = 1'b0;
      chk("we", mem_write_enable,
          (c >= 2 && c <= 2 * n && c % 2 == 0) ? 1 : 0);
      chk("busy", busy, (c <= 2 * n + 1) ? 1 : 0);
      chk("done", done, (c == 2 * n + 1) ? 1 : 0);
      if (c == 2 * n + 1) chk("sum", checksum, exp_sum);
    end
    chk("queue_empty", exp_q.size(), 0);
    chk_mem("mem");
  endtask

  initial begin
    int dc;
    vecs = 0; errs = 0; done_cnt = 0;
    start = 1'b0; src = '0; dst = '0; len = '0;
    pk_en = 1'b0; pk_a = '0; pk_d = '0;
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_we", mem_write_enable, 0);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    @(negedge clk);
    reset = 1'b0;

    poke(8'd200, 8'h05);
    poke(8'd201, 8'h0A);
    run_op(8'd200, 8'd50, 8'd2, -1);
    chk("basic_m50", mem[50], 8'h05);
    chk("basic_m51", mem[51], 8'h0A);
    chk("basic_sum", checksum, 8'h0F);

    run_op(8'd33, 8'd77, 8'd0, -1);
    chk("zero_sum", checksum, 8'h00);

    poke(8'hFF, 8'h11);
    poke(8'h00, 8'h22);
    poke(8'h01, 8'h33);
    run_op(8'hFF, 8'h80, 8'd3, -1);
    chk("wrap_m82", mem[8'h82], 8'h33);
    chk("wrap_sum", checksum, 8'h66);

    for (int i = 10; i <= 14; i++) poke(8'(i), 8'h80);
    run_op(8'd10, 8'd11, 8'd4, -1);
    chk("ovl_m14", mem[14], 8'h80);
    chk("ovl_sum", checksum, 8'h00);

    dc = done_cnt;
    run_op(8'd20, 8'd90, 8'd2, 2);
    repeat (8) begin
      @(negedge clk);
      chk("ign_idle", busy, 0);
    end
    chk("ign_done_cnt", done_cnt - dc, 1);
    chk("ign_queue", exp_q.size(), 0);

    for (int i = 0; i < 4; i++) poke(8'(120 + i), 8'(8'h40 + i));
    poke(8'd160, 8'hEE);
    poke(8'd161, 8'hDD);
    model(8'd120, 8'd160, 8'd4, 1);
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; src = 8'd120; dst = 8'd160; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_we", mem_write_enable, 0);
    chk("mid_sum", checksum, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_idle", busy, 0);
    chk("mid_done_cnt", done_cnt - dc, 0);
    chk("mid_queue", exp_q.size(), 0);
    chk("mid_m160", mem[160], 8'h40);
    chk("mid_m161", mem[161], 8'hDD);
    chk_mem("mid_mem");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
